fib_datapath: RTL and testbench

Execution datapath for the Fibonacci calculator. It sits directly downstream of the sequencing FSM and consumes that FSM's opcode, operand1, operand2 and DONE outputs every cycle. It contains a 4-entry register file (R0..R3), an adder/decrementer and a zero detector. It feeds ZERO_FLAG back to the FSM and presents the final Fibonacci result with a valid flag and a sticky overflow flag.

---
 rtl/fib_datapath.sv | 56 +++++
 tb/tb_fib_datapath.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fib_datapath.sv
// fib_datapath: 4-entry register file, adder/decrementer, zero test and result capture for the Fibonacci calculator
module fib_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [2:0]       opcode,
  input  logic [1:0]       operand1,
  input  logic [1:0]       operand2,
  input  logic             DONE,
  input  logic [WIDTH-1:0] DIN,
  output logic             ZERO_FLAG,
  output logic [WIDTH-1:0] RESULT,
  output logic             RESULT_VALID,
  output logic             OVF
);
  localparam logic [2:0] op_init = 3'b001;
  localparam logic [2:0] op_dec  = 3'b011;
  localparam logic [2:0] op_load = 3'b100;
  localparam logic [2:0] op_test = 3'b101;
  localparam logic [2:0] op_add  = 3'b110;
  localparam logic [2:0] op_mov  = 3'b111;
  logic [WIDTH-1:0] r [4];
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] wdata;
  logic             we;
  logic             test;
  always_comb begin
    sum   = {1'b0, r[operand1]} + {1'b0, r[operand2]};
    wdata = opcode == op_init ? WIDTH'(1) :
            opcode == op_dec  ? r[operand1] - WIDTH'(1) :
            opcode == op_load ? DIN :
            opcode == op_add  ? sum[WIDTH-1:0] : r[operand2];
    we    = opcode inside {op_init, op_dec, op_load, op_add, op_mov};
  end
  assign test      = opcode == op_test;
  // Unregistered: the FSM branches on this in the same cycle as the TEST
  assign ZERO_FLAG = test && r[operand1] == '0;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      r            <= '{default: '0};
      RESULT       <= '0;
      RESULT_VALID <= 1'b0;
      OVF          <= 1'b0;
    end else begin
      if (we) r[operand1] <= wdata;
      if (opcode == op_load) begin
        OVF          <= 1'b0;
        RESULT_VALID <= 1'b0;
      end else if (opcode == op_add && sum[WIDTH]) OVF <= 1'b1;
      if (DONE && test) begin
        RESULT       <= r[operand1];
        RESULT_VALID <= 1'b1;
      end
    end
endmodule

// File: tb/tb_fib_datapath.sv
// tb_fib_datapath: randomized scoreboard bench for fib_datapath against an arithmetic reference model
module tb_fib_datapath;
  localparam int W = 8;
  localparam int M = 1 << W;
  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [2:0]   opcode = '0;
  logic [1:0]   operand1 = '0;
  logic [1:0]   operand2 = '0;
  logic         DONE = 1'b0;
  logic [W-1:0] DIN = '0;
  logic         ZERO_FLAG;
  logic [W-1:0] RESULT;
  logic         RESULT_VALID;
  logic         OVF;
  typedef struct {int res; int val; int ovf;} exp_t;
  int   tests = 0;
  int   fails = 0;
  int   m [4];
  int   m_res = 0, m_val = 0, m_ovf = 0;
  bit   zq [$];
  exp_t oq [$];

  fib_datapath #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .opcode(opcode), .operand1(operand1), .operand2(operand2),
    .DONE(DONE), .DIN(DIN), .ZERO_FLAG(ZERO_FLAG), .RESULT(RESULT),
    .RESULT_VALID(RESULT_VALID), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int fib(input int k);
    int a = 1, b = 1, t;
    for (int i = 2; i < k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  // Drive one opcode for one cycle and record what the datapath must show for it
  task automatic op(input logic [2:0] o, input logic [1:0] d, input logic [1:0] s,
                    input logic dn, input logic [W-1:0] din);
    int t;
    @(negedge CLK);
    opcode = o; operand1 = d; operand2 = s; DONE = dn; DIN = din;
    zq.push_back(o == 3'd5 && m[d] == 0);
    case (o)
      3'd1: m[d] = 1;
      3'd3: m[d] = (m[d] + M - 1) % M;
      3'd4: begin m[d] = int'(din); m_ovf = 0; m_val = 0; end
      3'd5: if (dn) begin m_res = m[d]; m_val = 1; end
      3'd6: begin t = m[d] + m[s]; if (t >= M) m_ovf = 1; m[d] = t % M; end
      3'd7: m[d] = m[s];
      default: ;
    endcase
    oq.push_back('{m_res, m_val, m_ovf});
  endtask

  task automatic fib_seq(input int n);
    op(3'd4, 2'd0, 2'd0, 1'b0, W'(n));
    op(3'd1, 2'd1, 2'd0, 1'b0, '0);
    op(3'd1, 2'd2, 2'd0, 1'b0, '0);
    op(3'd5, 2'd0, 2'd0, 1'b0, '0);
    repeat (n) begin
      op(3'd7, 2'd3, 2'd1, 1'b0, '0);
      op(3'd6, 2'd1, 2'd2, 1'b0, '0);
      op(3'd7, 2'd2, 2'd3, 1'b0, '0);
      op(3'd3, 2'd0, 2'd0, 1'b0, '0);
      op(3'd5, 2'd0, 2'd0, 1'b0, '0);
    end
    op(3'd5, 2'd1, 2'd0, 1'b1, '0);
    op(3'd5, 2'd1, 2'd0, 1'b1, '0);
    @(posedge CLK); #2;
    chk("fib_result", RESULT, fib(n + 2) % M);
    chk("fib_valid", RESULT_VALID, 1);
    chk("fib_ovf", OVF, fib(n + 2) >= M);
  endtask

  initial forever begin
    @(negedge CLK); #1;
    if (zq.size() > 0) chk("zero_flag", ZERO_FLAG, zq.pop_front());
  end

  initial forever begin
    exp_t e;
    @(posedge CLK); #1;
    if (oq.size() > 0) begin
      e = oq.pop_front();
      chk("result", RESULT, e.res);
      chk("result_valid", RESULT_VALID, e.val);
      chk("ovf", OVF, e.ovf);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    m = '{default: 0};
    repeat (2) @(negedge CLK);
    chk("rst_valid", RESULT_VALID, 0);
    RST = 1'b0;
    // Build up non-zero RESULT, RESULT_VALID and OVF, then reset in the middle of an ADD
    op(3'd4, 2'd1, 2'd0, 1'b0, 8'd7);
    op(3'd4, 2'd2, 2'd0, 1'b0, 8'd200);
    op(3'd6, 2'd2, 2'd2, 1'b0, '0);
    op(3'd5, 2'd1, 2'd0, 1'b1, '0);
    @(negedge CLK);
    opcode = 3'd6; operand1 = 2'd1; operand2 = 2'd1; DONE = 1'b0;
    #2 RST = 1'b1;
    #1;
    chk("rst_result", RESULT, 0);
    chk("rst_result_valid", RESULT_VALID, 0);
    chk("rst_ovf", OVF, 0);
    opcode = 3'd5;
    for (int i = 0; i < 4; i++) begin
      operand1 = 2'(i);
      #1 chk("rst_reg_zero", ZERO_FLAG, 1);
    end
    m = '{default: 0};
    m_res = 0; m_val = 0; m_ovf = 0;
    @(negedge CLK);
    RST = 1'b0; opcode = 3'd0;
    fib_seq(3);
    fib_seq(1);
    op(3'd4, 2'd0, 2'd0, 1'b0, 8'd4);
    op(3'd0, 2'd0, 2'd0, 1'b0, '0);
    fib_seq(4);
    fib_seq(12);
    op(3'd4, 2'd0, 2'd0, 1'b0, 8'd5);
    // Boundary operations, observed through a capture
    op(3'd4, 2'd0, 2'd0, 1'b0, 8'd0);
    op(3'd3, 2'd0, 2'd0, 1'b0, '0);
    op(3'd5, 2'd0, 2'd0, 1'b1, '0);
    op(3'd4, 2'd1, 2'd0, 1'b0, 8'd3);
    op(3'd6, 2'd1, 2'd1, 1'b0, '0);
    op(3'd5, 2'd1, 2'd0, 1'b1, '0);
    op(3'd7, 2'd1, 2'd1, 1'b0, '0);
    op(3'd2, 2'd1, 2'd0, 1'b0, '0);
    op(3'd5, 2'd1, 2'd0, 1'b1, '0);
    @(posedge CLK); #2;
    chk("boundary_add_self", RESULT, 6);
    op(3'd4, 2'd0, 2'd0, 1'b0, 8'd0);
    for (int o = 0; o < 8; o++)
      if (o != 5) op(3'(o == 4 ? 0 : o), 2'd0, 2'd0, 1'b1, '0);
    op(3'd4, 2'd0, 2'd0, 1'b0, 8'd0);
    op(3'd0, 2'd0, 2'd0, 1'b1, '0);
    repeat (300)
      op(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
         1'($urandom_range(0, 1)), W'($urandom));
    repeat (6) fib_seq($urandom_range(0, 13));
    repeat (2) op(3'd0, 2'd0, 2'd0, 1'b0, '0);
    @(posedge CLK); #3;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
